// File: rtl/lbimatrix_iter_pkg.sv
// lbimatrix_pkg: state encoding, parity reduction and group-count helper for lbimatrix_iter
package lbimatrix_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int PAR_MAX = 1024;
  function automatic logic parity(input logic [PAR_MAX-1:0] v);
    return ^v;
  endfunction
  function automatic int groups(input int rows, input int lanes);
    return (rows + lanes - 1) / lanes;
  endfunction
endpackage

// File: rtl/lbimatrix_iter_if.sv
// lbimatrix_iter_if: seed-write, message-in and result-out handshakes of lbimatrix_iter
interface lbimatrix_iter_if #(parameter int ROW_W = 96, parameter int ROWS = 140);
  localparam int AW = $clog2(ROWS);
  logic seed_we;
  logic seed_sel;
  logic [AW-1:0] seed_addr;
  logic [ROW_W-1:0] seed_data;
  logic seed_err;
  logic in_valid;
  logic in_ready;
  logic [2*ROW_W-1:0] msg_in;
  logic out_valid;
  logic out_ready;
  logic [ROWS-1:0] msg_out;
  modport master(output seed_we, seed_sel, seed_addr, seed_data, in_valid, msg_in, out_ready,
                 input seed_err, in_ready, out_valid, msg_out);
  modport slave(input seed_we, seed_sel, seed_addr, seed_data, in_valid, msg_in, out_ready,
                output seed_err, in_ready, out_valid, msg_out);
endinterface

// File: rtl/lbimatrix_iter_lane.sv
// lbimatrix_lane: one row of the GF(2) bilinear form, parity(l&a) & parity(r&b)
module lbimatrix_lane import lbimatrix_pkg::*; #(parameter int ROW_W = 96) (
  input  logic [ROW_W-1:0] l,
  input  logic [ROW_W-1:0] r,
  input  logic [ROW_W-1:0] a,
  input  logic [ROW_W-1:0] b,
  output logic             y
);
  assign y = parity(PAR_MAX'(l & a)) & parity(PAR_MAX'(r & b));
endmodule

// File: rtl/lbimatrix_iter.sv
// lbimatrix_iter: iterative ROWS-bit bilinear transform, LANES rows per cycle, loadable row memories
module lbimatrix_iter import lbimatrix_pkg::*; #(
  parameter int ROW_W = 96,
  parameter int ROWS  = 140,
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst,
  lbimatrix_iter_if.slave bus
);
  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + LANES + 1);
  state_t state, state_nx;
  logic [CW-1:0] rc;
  logic [ROW_W-1:0] a_q, b_q;
  logic [ROWS-1:0] res;
  logic [ROW_W-1:0] l_mem [ROWS];
  logic [ROW_W-1:0] r_mem [ROWS];
  logic [LANES-1:0] hit;
  logic accept, last, seed_ok, seed_err_q;
  assign accept  = state == IDLE && bus.in_valid;
  assign last    = 32'(rc) + LANES >= ROWS;
  assign seed_ok = bus.seed_we && state != BUSY && 32'(bus.seed_addr) < ROWS;
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.msg_out   = res;
  assign bus.seed_err  = seed_err_q;
  always_comb begin
    state_nx = accept                              ? BUSY :
               (state == BUSY && last)             ? DONE :
               (state == DONE && bus.out_ready)    ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CW-1:0] idx;
    logic ok;
    assign idx = rc + CW'(k);
    assign ok  = 32'(idx) < ROWS;
    lbimatrix_lane #(.ROW_W(ROW_W)) u_lane (
      .l(ok ? l_mem[AW'(idx)] : '0),
      .r(ok ? r_mem[AW'(idx)] : '0),
      .a(a_q),
      .b(b_q),
      .y(hit[k])
    );
  end
  // lanes past the last row are zero-fed and additionally shifted out of the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc         <= '0;
      res        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= bus.seed_we && !seed_ok;
      if (accept) begin
        a_q <= bus.msg_in[ROW_W-1:0];
        b_q <= bus.msg_in[2*ROW_W-1:ROW_W];
        rc  <= '0;
        res <= '0;
      end else if (state == BUSY) begin
        rc  <= rc + CW'(LANES);
        res <= res | (ROWS'(hit) << rc);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        l_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else if (seed_ok) begin
      if (bus.seed_sel) r_mem[bus.seed_addr] <= bus.seed_data;
      else              l_mem[bus.seed_addr] <= bus.seed_data;
    end
  end
endmodule
